// File: rtl/tf_bus_pkg.sv
// Shared definitions for the 68k bus termination logic.
// Holds the controller state encoding, the default timing parameters and a
// helper that sizes the wait-state counter so it can reach TIMEOUT.
package tf_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACK     = 3'd2,
        ST_ERR     = 3'd3,
        ST_RELEASE = 3'd4
    } bus_state_e;

    localparam int DEF_WAIT_STATES = 4;
    localparam int DEF_TIMEOUT     = 64;
    localparam int DEF_SYNC_STAGES = 2;

    // Width needed for a counter that saturates at 'timeout'.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dtack_gen_if.sv
// Bus-side signal bundle of the DTACK generator.
//   AS     : 68k address strobe, active low, asynchronous to the clock
//   RW     : 68k read/write, high = read
//   SEL    : address decode hit from the target, active high
//   READY  : target ready, low extends the wait
//   DTACK  : data acknowledge, active low
//   BERR   : bus error, active low
//   OE     : pad enable for DTACK/BERR, low = tri-state
//   STROBE : one-clock pulse at an accepted cycle start
//   RW_L   : RW captured at cycle acceptance
//   BUSY   : controller is not idle
// slave  : the generator side; master : the bus/initiator side.
interface dtack_gen_if;
    logic AS;
    logic RW;
    logic SEL;
    logic READY;
    logic DTACK;
    logic BERR;
    logic OE;
    logic STROBE;
    logic RW_L;
    logic BUSY;

    modport slave (
        input  AS, RW, SEL, READY,
        output DTACK, BERR, OE, STROBE, RW_L, BUSY
    );

    modport master (
        output AS, RW, SEL, READY,
        input  DTACK, BERR, OE, STROBE, RW_L, BUSY
    );
endinterface

// File: rtl/dtack_gen_as_sync.sv
// Address-strobe synchroniser.
// Passes the asynchronous, active-low AS through SYNC_STAGES flops that
// reset to 1 (strobe negated).
//   clk      : sampling clock
//   rst      : synchronous, active-high reset
//   as_n     : raw asynchronous address strobe
//   as_s     : synchronised address strobe
//   as_valid : high once every stage holds a post-reset sample of AS, so
//              as_s no longer reflects the reset value of the chain
module as_sync
    import tf_bus_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic as_n,
    output logic as_s,
    output logic as_valid
);

    localparam int            FW         = $clog2(SYNC_STAGES + 1);
    localparam logic [FW-1:0] FLUSH_DONE = FW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            flush_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], as_n};
            if (flush_q != FLUSH_DONE) begin
                flush_q <= flush_q + FW'(1);
            end
        end
    end

    assign as_s     = sync_q[SYNC_STAGES-1];
    assign as_valid = (flush_q == FLUSH_DONE);

endmodule

// File: rtl/dtack_gen.sv
// 68k DTACK / BERR generator.
// Accepts a bus cycle when the synchronised AS falls while the target is
// selected, counts wait states, then terminates with DTACK (target ready
// after WAIT_STATES clocks) or BERR (no termination within TIMEOUT clocks).
// The chosen strobe is held until AS negates, then actively driven high for
// one clock before the pads are released.
//   CLKCPU : sole clock, rising edge
//   RESET  : synchronous, active-high reset
//   bus    : dtack_gen_if.slave (AS, RW, SEL, READY in; DTACK, BERR, OE,
//            STROBE, RW_L, BUSY out, all outputs registered)
module dtack_gen
    import tf_bus_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         CLKCPU,
    input  logic         RESET,
    dtack_gen_if.slave   bus
);

    localparam int            CW     = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] WS_CNT = CW'(WAIT_STATES);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    bus_state_e    state_q;
    logic [CW-1:0] count_q;
    logic          armed_q;
    logic          as_s;
    logic          as_valid;
    logic          ws_reached;

    as_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_as_sync (
        .clk      (CLKCPU),
        .rst      (RESET),
        .as_n     (bus.AS),
        .as_s     (as_s),
        .as_valid (as_valid)
    );

    // With zero wait states the threshold is always met; keeping the compare
    // out of that build avoids a degenerate unsigned >= 0.
    generate
        if (WAIT_STATES == 0) begin : g_ws_zero
            assign ws_reached = 1'b1;
        end else begin : g_ws_cmp
            assign ws_reached = (count_q >= WS_CNT);
        end
    endgenerate

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            armed_q    <= 1'b0;
            bus.DTACK  <= 1'b1;
            bus.BERR   <= 1'b1;
            bus.OE     <= 1'b0;
            bus.STROBE <= 1'b0;
            bus.RW_L   <= 1'b1;
            bus.BUSY   <= 1'b0;
        end else begin
            bus.STROBE <= 1'b0;

            // A cycle may only be accepted after AS has been seen negated.
            // Until the synchroniser is flushed, its reset value is not a real
            // observation, so an AS held low through reset stays foreign.
            if (as_valid && as_s) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (!as_s) begin
                        if (bus.SEL && armed_q) begin
                            state_q    <= ST_WAIT;
                            count_q    <= '0;
                            bus.RW_L   <= bus.RW;
                            bus.STROBE <= 1'b1;
                            bus.BUSY   <= 1'b1;
                        end else if (!bus.SEL) begin
                            armed_q <= 1'b0;
                        end
                    end
                end

                // Abort beats acknowledge, acknowledge beats timeout.
                ST_WAIT: begin
                    if (count_q != TO_CNT) begin
                        count_q <= count_q + CW'(1);
                    end
                    if (as_s) begin
                        state_q  <= ST_IDLE;
                        bus.BUSY <= 1'b0;
                    end else if (ws_reached && bus.READY) begin
                        state_q   <= ST_ACK;
                        bus.DTACK <= 1'b0;
                        bus.OE    <= 1'b1;
                    end else if (count_q == TO_CNT) begin
                        state_q  <= ST_ERR;
                        bus.BERR <= 1'b0;
                        bus.OE   <= 1'b1;
                    end
                end

                ST_ACK, ST_ERR: begin
                    if (as_s) begin
                        state_q   <= ST_RELEASE;
                        bus.DTACK <= 1'b1;
                        bus.BERR  <= 1'b1;
                    end
                end

                ST_RELEASE: begin
                    state_q  <= ST_IDLE;
                    bus.OE   <= 1'b0;
                    bus.BUSY <= 1'b0;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    bus.DTACK <= 1'b1;
                    bus.BERR  <= 1'b1;
                    bus.OE    <= 1'b0;
                    bus.BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtack_gen.sv
// Directed bench for dtack_gen: one instance with four wait states and one
// with zero, both sharing the same bus stimulus.
module tb_dtack_gen;
    import tf_bus_pkg::*;

    logic clk;
    logic rst;
    logic as_n;
    logic rw;
    logic sel;
    logic ready;

    dtack_gen_if ifa ();
    dtack_gen_if ifb ();

    assign ifa.AS    = as_n;
    assign ifa.RW    = rw;
    assign ifa.SEL   = sel;
    assign ifa.READY = ready;
    assign ifb.AS    = as_n;
    assign ifb.RW    = rw;
    assign ifb.SEL   = sel;
    assign ifb.READY = ready;

    dtack_gen #(.WAIT_STATES(4), .TIMEOUT(64), .SYNC_STAGES(2)) dut_a (
        .CLKCPU (clk),
        .RESET  (rst),
        .bus    (ifa)
    );

    dtack_gen #(.WAIT_STATES(0), .TIMEOUT(64), .SYNC_STAGES(2)) dut_b (
        .CLKCPU (clk),
        .RESET  (rst),
        .bus    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit a_dtack_low, a_berr_low, a_oe_hi, a_strobe_hi, a_busy_hi, both_low;

    localparam int A_STROBE = 0;
    localparam int A_DTACK  = 1;
    localparam int A_BERR   = 2;
    localparam int B_STROBE = 3;
    localparam int B_DTACK  = 4;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed %0d with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clear_flags();
        a_dtack_low = 0;
        a_berr_low  = 0;
        a_oe_hi     = 0;
        a_strobe_hi = 0;
        a_busy_hi   = 0;
    endtask

    // One clock; samples on the falling edge and updates the sticky monitors.
    task automatic tick();
        @(negedge clk);
        if (ifa.DTACK === 1'b0)  a_dtack_low = 1;
        if (ifa.BERR === 1'b0)   a_berr_low  = 1;
        if (ifa.OE === 1'b1)     a_oe_hi     = 1;
        if (ifa.STROBE === 1'b1) a_strobe_hi = 1;
        if (ifa.BUSY === 1'b1)   a_busy_hi   = 1;
        if ((ifa.DTACK === 1'b0 && ifa.BERR === 1'b0) ||
            (ifb.DTACK === 1'b0 && ifb.BERR === 1'b0)) both_low = 1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            A_STROBE: return ifa.STROBE;
            A_DTACK:  return ifa.DTACK;
            A_BERR:   return ifa.BERR;
            B_STROBE: return ifb.STROBE;
            default:  return ifb.DTACK;
        endcase
    endfunction

    // Clocks until the selected output takes 'val'; all-ones if it never does.
    task automatic wait_sig(input int which, input logic val, input int limit,
                            output logic [31:0] k);
        bit found;
        found = 0;
        k = '1;
        for (int i = 1; i <= limit && !found; i++) begin
            tick();
            if (sig(which) === val) begin
                found = 1;
                k = i;
            end
        end
    endtask

    initial begin
        logic [31:0] k;
        logic        rwv;

        rst = 1; as_n = 1; rw = 1; sel = 1; ready = 1;
        clear_flags();
        both_low = 0;
        repeat (3) tick();
        sb_push("rst_dtack", 1);  sb_check(ifa.DTACK);
        sb_push("rst_berr", 1);   sb_check(ifa.BERR);
        sb_push("rst_oe", 0);     sb_check(ifa.OE);
        sb_push("rst_strobe", 0); sb_check(ifa.STROBE);
        sb_push("rst_rwl", 1);    sb_check(ifa.RW_L);
        sb_push("rst_busy", 0);   sb_check(ifa.BUSY);
        rst = 0;
        repeat (4) tick();

        // Basic read cycle, four wait states
        sb_push("t1_strobe_lat", 3);
        as_n = 0;
        wait_sig(A_STROBE, 1'b1, 10, k); sb_check(k);
        sb_push("t1_rwl", 1); sb_check(ifa.RW_L);
        clear_flags();
        sb_push("t1_dtack_lat", 5);
        wait_sig(A_DTACK, 1'b0, 20, k); sb_check(k);
        sb_push("t1_strobe_pulse", 0); sb_check(a_strobe_hi);
        sb_push("t1_berr_quiet", 0);   sb_check(a_berr_low);
        sb_push("t1_oe_ack", 1);       sb_check(ifa.OE);
        repeat (3) tick();
        sb_push("t1_dtack_hold", 0);   sb_check(ifa.DTACK);
        sb_push("t1_release_lat", 3);
        as_n = 1;
        wait_sig(A_DTACK, 1'b1, 10, k); sb_check(k);
        sb_push("t1_oe_release", 1); sb_check(ifa.OE);
        tick();
        sb_push("t1_oe_idle", 0);    sb_check(ifa.OE);
        sb_push("t1_busy_idle", 0);  sb_check(ifa.BUSY);
        repeat (3) tick();

        // Zero wait states, write then read, RW changed after acceptance
        for (int p = 0; p < 2; p++) begin
            rwv = (p == 1);
            rw  = rwv;
            sb_push("t2_strobe_lat", 3);
            as_n = 0;
            wait_sig(B_STROBE, 1'b1, 10, k); sb_check(k);
            sb_push("t2_rwl", {31'd0, rwv}); sb_check(ifb.RW_L);
            rw = !rwv;
            sb_push("t2_dtack_lat", 1);
            wait_sig(B_DTACK, 1'b0, 10, k); sb_check(k);
            sb_push("t2_rwl_hold", {31'd0, rwv}); sb_check(ifb.RW_L);
            sb_push("t2_release_lat", 3);
            as_n = 1;
            wait_sig(B_DTACK, 1'b1, 10, k); sb_check(k);
            repeat (4) tick();
        end

        // READY held low for ten clocks past the wait-state count
        ready = 0;
        sb_push("t3_strobe_lat", 3);
        as_n = 0;
        wait_sig(A_STROBE, 1'b1, 10, k); sb_check(k);
        clear_flags();
        repeat (14) tick();
        sb_push("t3_no_dtack", 0); sb_check(a_dtack_low);
        sb_push("t3_no_berr", 0);  sb_check(a_berr_low);
        sb_push("t3_dtack_lat", 1);
        ready = 1;
        wait_sig(A_DTACK, 1'b0, 10, k); sb_check(k);
        sb_push("t3_berr_high", 1); sb_check(ifa.BERR);
        sb_push("t3_release_lat", 3);
        as_n = 1;
        wait_sig(A_DTACK, 1'b1, 10, k); sb_check(k);
        repeat (4) tick();

        // Target never ready: bus error after TIMEOUT
        ready = 0;
        sb_push("t4_strobe_lat", 3);
        as_n = 0;
        wait_sig(A_STROBE, 1'b1, 10, k); sb_check(k);
        clear_flags();
        sb_push("t4_berr_lat", 65);
        wait_sig(A_BERR, 1'b0, 100, k); sb_check(k);
        sb_push("t4_no_dtack", 0); sb_check(a_dtack_low);
        sb_push("t4_oe", 1);       sb_check(ifa.OE);
        sb_push("t4_release_lat", 3);
        as_n = 1;
        wait_sig(A_BERR, 1'b1, 10, k); sb_check(k);
        sb_push("t4_release_oe", 1);   sb_check(ifa.OE);
        sb_push("t4_release_busy", 1); sb_check(ifa.BUSY);
        tick();
        sb_push("t4_idle_oe", 0);      sb_check(ifa.OE);
        repeat (3) tick();
        ready = 1;

        // Initiator abort at count 2 (meets ACK condition in the same clock)
        sb_push("t5_strobe_lat", 3);
        as_n = 0;
        wait_sig(A_STROBE, 1'b1, 10, k); sb_check(k);
        repeat (2) tick();
        as_n = 1;
        clear_flags();
        repeat (6) tick();
        sb_push("t5_no_dtack", 0); sb_check(a_dtack_low);
        sb_push("t5_no_berr", 0);  sb_check(a_berr_low);
        sb_push("t5_oe_low", 0);   sb_check(a_oe_hi);
        sb_push("t5_busy", 0);     sb_check(ifa.BUSY);

        // Foreign cycle, then SEL rising while AS is still low
        sel = 0;
        as_n = 0;
        clear_flags();
        repeat (8) tick();
        sb_push("t5_foreign_strobe", 0); sb_check(a_strobe_hi);
        sb_push("t5_foreign_busy", 0);   sb_check(a_busy_hi);
        sel = 1;
        clear_flags();
        repeat (6) tick();
        sb_push("t5_rearm_strobe", 0);   sb_check(a_strobe_hi);
        as_n = 1;
        repeat (4) tick();
        rw = 0;
        sb_push("t5_accept_lat", 3);
        as_n = 0;
        wait_sig(A_STROBE, 1'b1, 10, k); sb_check(k);
        sb_push("t5_dtack_lat", 5);
        wait_sig(A_DTACK, 1'b0, 20, k); sb_check(k);

        // Reset while acknowledging with AS still low
        rst = 1;
        tick();
        sb_push("t6_dtack", 1); sb_check(ifa.DTACK);
        sb_push("t6_oe", 0);    sb_check(ifa.OE);
        sb_push("t6_busy", 0);  sb_check(ifa.BUSY);
        sb_push("t6_rwl", 1);   sb_check(ifa.RW_L);
        rst = 0;
        clear_flags();
        repeat (8) tick();
        sb_push("t6_no_strobe", 0); sb_check(a_strobe_hi);
        as_n = 1;
        repeat (4) tick();
        rw = 1;
        sb_push("t6_accept_lat", 3);
        as_n = 0;
        wait_sig(A_STROBE, 1'b1, 10, k); sb_check(k);
        sb_push("t6_dtack_lat", 5);
        wait_sig(A_DTACK, 1'b0, 20, k); sb_check(k);
        as_n = 1;
        repeat (5) tick();

        sb_push("dtack_berr_both_low", 0); sb_check(both_low);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtack_gen.md
DTACK_GEN -- requirements
Module: dtack_gen

Interface
REQ-001 Parameter WAIT_STATES, default 4, clocks between cycle start and DTACK assertion (0..TIMEOUT-1).
REQ-002 Parameter TIMEOUT, default 64, clocks in WAIT before bus error; SHALL exceed WAIT_STATES.
REQ-003 Parameter SYNC_STAGES, default 2, AS synchroniser depth (min 2).
REQ-004 CLKCPU  input  1  sole clock, all state on rising edge.
REQ-005 RESET  input  1  reset: synchronous and active-high.
REQ-006 AS  input  1  68k address strobe, active low, asynchronous.
REQ-007 RW  input  1  68k read/write, high = read.
REQ-008 SEL  input  1  address decode hit from target, active high.
REQ-009 READY  input  1  target ready, high = may terminate; low extends wait.
REQ-010 DTACK  output  1  data acknowledge, active low.
REQ-011 BERR  output  1  bus error, active low.
REQ-012 OE  output  1  high = drive DTACK/BERR pads; low = tri-state.
REQ-013 STROBE  output  1  one-clock pulse marking accepted cycle start.
REQ-014 RW_L  output  1  RW latched at cycle acceptance.
REQ-015 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-016 AS SHALL pass through SYNC_STAGES flops (reset value 1) to form as_s; no other logic uses raw AS.
REQ-017 States SHALL be IDLE, WAIT, ACK, ERR, RELEASE; all outputs registered.
REQ-018 IDLE: as_s=0 and SEL=1 -> WAIT, count cleared to 0, RW_L<=RW, STROBE=1 for the first WAIT clock only.
REQ-019 IDLE: as_s=0 and SEL=0 -> stay IDLE, outputs unchanged (foreign cycle ignored until as_s returns 1).
REQ-020 After a foreign cycle, a new acceptance SHALL require as_s to have been 1 for at least one clock.
REQ-021 WAIT: count increments by 1 per clock, saturating at TIMEOUT; width clog2(TIMEOUT+1).
REQ-022 WAIT: count>=WAIT_STATES and READY=1 -> ACK; DTACK low in first ACK clock, i.e. WAIT_STATES+1 clocks after STROBE high.
REQ-023 WAIT: count=TIMEOUT without ACK -> ERR; BERR low in first ERR clock.
REQ-024 WAIT: as_s=1 (initiator abort) -> IDLE directly, no DTACK/BERR asserted; abort has priority over ACK and ERR in the same clock.
REQ-025 ACK/ERR: hold DTACK (resp. BERR) low with OE=1 until as_s=1, then -> RELEASE.
REQ-026 RELEASE: DTACK=1, BERR=1, OE=1 for exactly one clock (active negation), then IDLE with OE=0.
REQ-027 DTACK and BERR SHALL never be low in the same clock.
REQ-028 SEL and RW SHALL be ignored outside IDLE; READY ignored outside WAIT.

Reset
REQ-029 RESET=1 at a clock edge SHALL force IDLE, count=0, DTACK=1, BERR=1, OE=0, STROBE=0, RW_L=1, BUSY=0, sync flops=1.
REQ-030 Reset mid-cycle SHALL release pads on the next edge; a still-low AS after reset SHALL be treated as foreign until it returns high (REQ-020).

Structure
REQ-031 State enumeration and default parameter constants SHALL reside in shared package tf_bus_pkg.
REQ-032 The synchroniser SHALL be sub-module as_sync (parameter SYNC_STAGES, reset value 1); FSM and counter stay in dtack_gen.

Verification
REQ-033 WAIT_STATES=4, READY=1, SEL=1, AS low -> STROBE at clock N, DTACK low at N+5, high one clock after as_s=1, OE low one clock later.
REQ-034 WAIT_STATES=0, READY=1 -> DTACK low one clock after STROBE; RW_L equals RW sampled at acceptance (read=1 and write=0 both checked).
REQ-035 READY=0 for 10 clocks past count=4, then 1 -> DTACK low one clock after READY rises; BERR stays 1.
REQ-036 READY=0 permanently, TIMEOUT=64 -> BERR low 65 clocks after STROBE, DTACK never low, RELEASE clock seen after AS high.
REQ-037 AS deasserted at count=2 -> IDLE, no DTACK/BERR pulse, OE stays 0; SEL=0 cycle -> no STROBE, BUSY=0 throughout.
REQ-038 RESET pulsed while in ACK with AS held low -> DTACK=1, OE=0 next edge; no new STROBE until AS high then low again.
